// File: rtl/block_stream_checker_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : block_stream_checker_if                                       |
// | Purpose  : Bundles the block stream under test and the golden-memory     |
// |            read port used by block_stream_checker.                       |
// | Signals  : dut_valid  - dut_data carries a block this cycle              |
// |            dut_data   - block under test (DATA_W bits)                   |
// |            gold_addr  - golden read address from the checker             |
// |            gold_rdata - golden data for previous cycle's gold_addr       |
// | Modports : master - stream source + golden memory side                   |
// |            slave  - checker side                                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface block_stream_checker_if #(
    parameter int DATA_W = 704,
    parameter int ADDR_W = 11
);
    logic              dut_valid;
    logic [DATA_W-1:0] dut_data;
    logic [ADDR_W-1:0] gold_addr;
    logic [DATA_W-1:0] gold_rdata;

    modport master (
        output dut_valid,
        output dut_data,
        output gold_rdata,
        input  gold_addr
    );

    modport slave (
        input  dut_valid,
        input  dut_data,
        input  gold_rdata,
        output gold_addr
    );
endinterface
`default_nettype wire

// File: rtl/block_stream_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : block_stream_checker                                          |
// | Purpose  : In-design scoreboard for the colour/DCT/quant pipeline.       |
// |            Compares each emitted block (channel-major order) against a   |
// |            golden memory stored channel-interleaved                      |
// |            (index = ch + NUM_CH*blk), counts mismatches and reports      |
// |            per-channel and overall pass.                                 |
// | Ports    : clk, rst          - clock, asynchronous active-high reset     |
// |            start_i           - 1-cycle pulse, starts a run (IDLE/DONE)   |
// |            bus (slave)       - dut_valid/dut_data in, gold_addr out,     |
// |                                gold_rdata in (1-cycle sync read)         |
// |            busy_o, done_o    - run in progress / run finished            |
// |            pass_o            - done with zero mismatches                 |
// |            ch_pass_o         - per channel: no mismatch seen             |
// |            ch_done_o         - per channel: all blocks checked           |
// |            err_cnt_o         - saturating mismatch count                 |
// |            proto_err_o       - sticky: dut_valid seen outside RUN        |
// |            first_err_addr_o  - golden index of first mismatch            |
// |            first_err_vld_o   - first_err_addr_o is valid                 |
// | Config   : CHECK_FIRST_ERR_EN - when defined, first-mismatch capture     |
// |            registers exist; otherwise first_err_* are tied to 0.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module block_stream_checker #(
    parameter int DATA_W      = 704,
    parameter int NUM_CH      = 3,
    parameter int BLK_PER_CH  = 576,
    parameter int ADDR_W      = 11,
    parameter int ERR_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  start_i,
    block_stream_checker_if.slave      bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [NUM_CH-1:0]          ch_pass_o,
    output logic [NUM_CH-1:0]          ch_done_o,
    output logic [ERR_W-1:0]           err_cnt_o,
    output logic                       proto_err_o,
    output logic [ADDR_W-1:0]          first_err_addr_o,
    output logic                       first_err_vld_o
);

    localparam int CH_W  = (NUM_CH > 1)     ? $clog2(NUM_CH)     : 1;
    localparam int BLK_W = (BLK_PER_CH > 1) ? $clog2(BLK_PER_CH) : 1;

    localparam logic [CH_W-1:0]   C_CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [BLK_W-1:0]  C_BLK_LAST = BLK_W'(BLK_PER_CH - 1);
    localparam logic [ADDR_W-1:0] C_NUM_CH_A = ADDR_W'(NUM_CH);
    localparam logic [ERR_W-1:0]  C_ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q,  ch_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               busy_q, done_q, pass_q, proto_err_q;
    logic [NUM_CH-1:0]  ch_pass_q, ch_done_q;

    logic [DATA_W-1:0]  w_dut_data, w_gold_data;
    logic               w_beat, w_mism, w_wrap, w_last, w_stop, w_finish, w_restart;

    assign w_dut_data  = bus.dut_data;
    assign w_gold_data = bus.gold_rdata;

    // Next-counter logic. Counters fall back to zero when a run finishes so
    // that the golden address is already pointing at index 0 for the next run.
    always_comb begin
        w_beat    = (state_q == S_RUN) && bus.dut_valid;
        w_mism    = w_beat && (w_dut_data != w_gold_data);
        w_wrap    = w_beat && (blk_q == C_BLK_LAST);
        w_last    = w_wrap && (ch_q == C_CH_LAST);
        w_stop    = (STOP_ON_ERR != 0) && w_mism;
        w_finish  = w_last || w_stop;
        w_restart = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

        ch_d  = ch_q;
        blk_d = blk_q;
        if (w_finish) begin
            ch_d  = '0;
            blk_d = '0;
        end else if (w_wrap) begin
            ch_d  = ch_q + CH_W'(1);
            blk_d = '0;
        end else if (w_beat) begin
            blk_d = blk_q + BLK_W'(1);
        end

        err_cnt_d = err_cnt_q;
        if (w_mism && (err_cnt_q != C_ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Address of the next expected beat, taken from the post-update counters:
    // the synchronous memory then returns that beat's golden block in the very
    // cycle the beat arrives.
    assign bus.gold_addr = ADDR_W'(ch_d) + C_NUM_CH_A * ADDR_W'(blk_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            blk_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            ch_pass_q   <= '1;
            ch_done_q   <= '0;
            err_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            ch_q  <= ch_d;
            blk_q <= blk_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_PRIME;
                        busy_q  <= 1'b1;
                    end
                end
                S_PRIME: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    err_cnt_q <= err_cnt_d;
                    if (w_mism) begin
                        ch_pass_q[ch_q] <= 1'b0;
                    end
                    if (w_wrap) begin
                        ch_done_q[ch_q] <= 1'b1;
                    end
                    if (w_finish) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end
                end
                S_DONE: begin
                    if (start_i) begin
                        state_q     <= S_PRIME;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        ch_pass_q   <= '1;
                        ch_done_q   <= '0;
                        err_cnt_q   <= '0;
                        proto_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // Placed last so a stray beat in the same cycle as a restart still
            // leaves the flag set.
            if (bus.dut_valid && (state_q != S_RUN)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign ch_pass_o   = ch_pass_q;
    assign ch_done_o   = ch_done_q;
    assign err_cnt_o   = err_cnt_q;
    assign proto_err_o = proto_err_q;

`ifdef CHECK_FIRST_ERR_EN
    logic [ADDR_W-1:0] first_err_addr_q;
    logic              first_err_vld_q;
    logic [ADDR_W-1:0] w_cur_idx;

    // Golden index of the beat currently being compared.
    assign w_cur_idx = ADDR_W'(ch_q) + C_NUM_CH_A * ADDR_W'(blk_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
        end else if (w_restart) begin
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
        end else if (w_mism && !first_err_vld_q) begin
            first_err_addr_q <= w_cur_idx;
            first_err_vld_q  <= 1'b1;
        end
    end

    assign first_err_addr_o = first_err_addr_q;
    assign first_err_vld_o  = first_err_vld_q;
`else
    logic w_unused_restart;
    assign w_unused_restart = w_restart;
    assign first_err_addr_o = '0;
    assign first_err_vld_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_stream_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_block_stream_checker                                       |
// | Purpose  : Self-checking bench for block_stream_checker. Three instances |
// |            share one stimulus stream: u0 plain, u1 stop-on-error, u2     |
// |            with a 2-bit error counter. Each has its own golden memory.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_block_stream_checker;

    localparam int DW  = 16;
    localparam int NCH = 3;
    localparam int BPC = 4;
    localparam int AW  = 4;
    localparam int NB  = NCH * BPC;

`ifdef CHECK_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic vld;
    logic [DW-1:0] data;

    always #5 clk = ~clk;

    block_stream_checker_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    block_stream_checker_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    block_stream_checker_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

    assign if0.dut_valid = vld;
    assign if1.dut_valid = vld;
    assign if2.dut_valid = vld;
    assign if0.dut_data  = data;
    assign if1.dut_data  = data;
    assign if2.dut_data  = data;

    function automatic logic [DW-1:0] gold_of(input int i);
        return DW'(32'h100 + i);
    endfunction

    // Golden memories: one-cycle synchronous read.
    always @(posedge clk) begin
        if0.gold_rdata <= gold_of(int'(if0.gold_addr));
        if1.gold_rdata <= gold_of(int'(if1.gold_addr));
        if2.gold_rdata <= gold_of(int'(if2.gold_addr));
    end

    logic              busy [3];
    logic              done [3];
    logic              pass [3];
    logic              proto[3];
    logic              fvld [3];
    logic [NCH-1:0]    chp  [3];
    logic [NCH-1:0]    chd  [3];
    logic [AW-1:0]     fea  [3];
    logic [15:0]       err0, err1;
    logic [1:0]        err2;

    block_stream_checker #(.DATA_W(DW), .NUM_CH(NCH), .BLK_PER_CH(BPC), .ADDR_W(AW),
                           .ERR_W(16), .STOP_ON_ERR(0)) u0 (
        .clk(clk), .rst(rst), .start_i(start), .bus(if0),
        .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .ch_pass_o(chp[0]),
        .ch_done_o(chd[0]), .err_cnt_o(err0), .proto_err_o(proto[0]),
        .first_err_addr_o(fea[0]), .first_err_vld_o(fvld[0]));

    block_stream_checker #(.DATA_W(DW), .NUM_CH(NCH), .BLK_PER_CH(BPC), .ADDR_W(AW),
                           .ERR_W(16), .STOP_ON_ERR(1)) u1 (
        .clk(clk), .rst(rst), .start_i(start), .bus(if1),
        .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .ch_pass_o(chp[1]),
        .ch_done_o(chd[1]), .err_cnt_o(err1), .proto_err_o(proto[1]),
        .first_err_addr_o(fea[1]), .first_err_vld_o(fvld[1]));

    block_stream_checker #(.DATA_W(DW), .NUM_CH(NCH), .BLK_PER_CH(BPC), .ADDR_W(AW),
                           .ERR_W(2), .STOP_ON_ERR(0)) u2 (
        .clk(clk), .rst(rst), .start_i(start), .bus(if2),
        .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .ch_pass_o(chp[2]),
        .ch_done_o(chd[2]), .err_cnt_o(err2), .proto_err_o(proto[2]),
        .first_err_addr_o(fea[2]), .first_err_vld_o(fvld[2]));

    int total = 0;
    int bad   = 0;

    // Reference model state: beat k of the stream is channel k/BPC, block k%BPC.
    logic [DW-1:0] bd [NB];
    bit            mism [NB];
    int            n_m;
    int            first_k;
    bit            prime_v;
    int            gap_lo, gap_hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input int k);
        return (k / BPC) + NCH * (k % BPC);
    endfunction

    // Channels fully delivered once beat k has been accepted.
    function automatic int chd_exp(input int k);
        int m = 0;
        for (int c = 0; c < NCH; c++) if (BPC * c + BPC - 1 <= k) m |= (1 << c);
        return m;
    endfunction

    function automatic int mism_upto(input int k);
        int n = 0;
        for (int j = 0; j <= k; j++) if (mism[j]) n++;
        return n;
    endfunction

    task automatic set_gold();
        for (int k = 0; k < NB; k++) bd[k] = gold_of(idx_of(k));
    endtask

    task automatic prepare();
        n_m = 0;
        first_k = -1;
        for (int k = 0; k < NB; k++) begin
            mism[k] = (bd[k] !== gold_of(idx_of(k)));
            if (mism[k]) begin
                n_m++;
                if (first_k < 0) first_k = k;
            end
        end
    endtask

    task automatic start_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_prime", 32'(busy[0]), 32'd1);
        check("done_prime", 32'(done[0]), 32'd0);
        if (prime_v) begin
            vld  = 1'b1;
            data = DW'($urandom);
        end
        @(posedge clk); #1 vld = 1'b0;
    endtask

    task automatic run_beats(input int n);
        for (int k = 0; k < n; k++) begin
            int gap = int'($urandom_range(gap_hi, gap_lo));
            repeat (gap) begin
                @(negedge clk);
                check("gold_addr_gap", 32'(if0.gold_addr), 32'(idx_of(k)));
                @(posedge clk); #1;
            end
            vld  = 1'b1;
            data = bd[k];
            @(negedge clk);
            check("gold_addr_next", 32'(if0.gold_addr), (k == NB - 1) ? 32'd0 : 32'(idx_of(k + 1)));
            @(posedge clk); #1 vld = 1'b0;
            check("err_running", 32'(err0), 32'(mism_upto(k)));
            check("ch_done_running", 32'(chd[0]), 32'(chd_exp(k)));
            check("stop_done", 32'(done[1]), 32'((first_k >= 0 && k >= first_k) || k == NB - 1));
        end
    endtask

    task automatic check_final();
        int chp_all = (1 << NCH) - 1;
        int chp1, chd1, e1, pr1, e2;
        for (int k = 0; k < NB; k++) if (mism[k]) chp_all &= ~(1 << (k / BPC));
        e2 = (n_m > 3) ? 3 : n_m;
        if (first_k < 0) begin
            chp1 = (1 << NCH) - 1; chd1 = (1 << NCH) - 1; e1 = 0; pr1 = int'(prime_v);
        end else begin
            chp1 = ((1 << NCH) - 1) & ~(1 << (first_k / BPC));
            chd1 = chd_exp(first_k);
            e1   = 1;
            pr1  = int'(prime_v || (first_k < NB - 1));
        end
        check("done0", 32'(done[0]), 32'd1);
        check("busy0", 32'(busy[0]), 32'd0);
        check("pass0", 32'(pass[0]), 32'(n_m == 0));
        check("err0", 32'(err0), 32'(n_m));
        check("ch_pass0", 32'(chp[0]), 32'(chp_all));
        check("ch_done0", 32'(chd[0]), 32'((1 << NCH) - 1));
        check("proto0", 32'(proto[0]), 32'(prime_v));
        check("gold_addr_end", 32'(if0.gold_addr), 32'd0);
        check("done1", 32'(done[1]), 32'd1);
        check("busy1", 32'(busy[1]), 32'd0);
        check("pass1", 32'(pass[1]), 32'(first_k < 0));
        check("err1", 32'(err1), 32'(e1));
        check("ch_pass1", 32'(chp[1]), 32'(chp1));
        check("ch_done1", 32'(chd[1]), 32'(chd1));
        check("proto1", 32'(proto[1]), 32'(pr1));
        check("err2_sat", 32'(err2), 32'(e2));
        check("pass2", 32'(pass[2]), 32'(n_m == 0));
        check("ch_pass2", 32'(chp[2]), 32'(chp_all));
        for (int i = 0; i < 3; i++) begin
            check("first_err_vld", 32'(fvld[i]), 32'(FE && first_k >= 0));
            check("first_err_addr", 32'(fea[i]), (FE && first_k >= 0) ? 32'(idx_of(first_k)) : 32'd0);
        end
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy[i]), 32'd0);
            check("rst_done", 32'(done[i]), 32'd0);
            check("rst_pass", 32'(pass[i]), 32'd0);
            check("rst_ch_pass", 32'(chp[i]), 32'((1 << NCH) - 1));
            check("rst_ch_done", 32'(chd[i]), 32'd0);
            check("rst_proto", 32'(proto[i]), 32'd0);
            check("rst_first_vld", 32'(fvld[i]), 32'd0);
        end
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_err1", 32'(err1), 32'd0);
        check("rst_err2", 32'(err2), 32'd0);
        check("rst_gold_addr", 32'(if0.gold_addr), 32'd0);
    endtask

    task automatic full_run();
        prepare();
        start_run();
        run_beats(NB);
        check_final();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; vld = 1'b0; data = '0;
        prime_v = 1'b0; gap_lo = 0; gap_hi = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals();
        rst = 1'b0;

        // Clean back-to-back run.
        set_gold();
        full_run();

        // Golden index 4 corrupted, two-cycle gaps.
        set_gold(); bd[5] = 16'hDEAD; gap_lo = 2; gap_hi = 2;
        full_run();

        // Golden index 6 corrupted: stop-on-error instance ends after third beat.
        set_gold(); bd[2] = 16'hBEEF; gap_lo = 0; gap_hi = 1;
        full_run();

        // Stray beat during PRIME.
        set_gold(); prime_v = 1'b1; gap_lo = 0; gap_hi = 0;
        full_run();
        prime_v = 1'b0;

        // Reset in the middle of a run, then a full clean run from IDLE.
        set_gold(); bd[1] = 16'h0BAD;
        prepare();
        start_run();
        run_beats(5);
        rst = 1'b1;
        #2 check_reset_vals();
        @(posedge clk); #1 rst = 1'b0;
        set_gold();
        full_run();

        // Every beat wrong: 2-bit counter saturates.
        for (int k = 0; k < NB; k++) bd[k] = ~gold_of(idx_of(k));
        full_run();

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            set_gold();
            for (int k = 0; k < NB; k++)
                if ($urandom_range(3, 0) == 0) bd[k] = bd[k] ^ DW'($urandom_range(65535, 1));
            prime_v = ($urandom_range(3, 0) == 0);
            gap_lo = 0; gap_hi = 3;
            full_run();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
